// File: rtl/ctrl_pkg.sv
// Shared constants for the multi-cycle RV32I sequencing controller.
package ctrl_pkg;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic PC_SRC_SEQ = 1'b0;
  localparam logic PC_SRC_TGT = 1'b1;

  localparam logic WB_ALU = 1'b0;
  localparam logic WB_MEM = 1'b1;

  localparam int unsigned DEFAULT_MEM_TIMEOUT = 16;
endpackage

// File: rtl/bus_timeout_counter.sv
// Counts cycles a memory request has been waiting; expired flags the last permitted cycle.
module bus_timeout_counter
  import ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = DEFAULT_MEM_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == 8'(LIMIT - 1));
endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing FSM: fetch, decode, execute, memory, writeback and retire.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             trap_clr,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             dec_valid,
  input  logic             dec_mem_write_en,
  input  logic             dec_mem_to_reg,
  input  logic             dec_reg_write_en,
  input  logic             dec_branch_en,
  input  logic             dec_jump_en,
  input  logic             alu_zero,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic             wb_sel,
  output logic             pc_we,
  output logic             pc_src,
  output logic             busy,
  output logic             trap,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired
);
  logic [2:0] state;
  logic [2:0] next;
  logic       retire;
  logic       waiting;
  logic       expired;

  // Counter runs only while a request is outstanding; any other cycle clears it,
  // which covers entry into FETCH/MEM from every predecessor (including MEM->FETCH).
  assign waiting = ((state == S_FETCH) && !imem_ready) ||
                   ((state == S_MEM)   && !dmem_ready);

  bus_timeout_counter #(.LIMIT(MEM_TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!waiting),
    .en      (waiting),
    .expired (expired)
  );

  always_comb begin
    next    = state;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    pc_src  = PC_SRC_SEQ;
    rf_we   = 1'b0;
    dmem_we = 1'b0;
    wb_sel  = WB_ALU;
    retire  = 1'b0;
    case (state)
      S_IDLE:   if (run) next = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          ir_we = 1'b1;
          next  = S_DECODE;
        end else if (expired) begin
          next = S_TRAP;
        end
      end
      S_DECODE: next = dec_valid ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (dec_branch_en) begin
          pc_we  = 1'b1;
          pc_src = alu_zero;
          retire = 1'b1;
        end else if (dec_mem_write_en || dec_mem_to_reg) begin
          next = S_MEM;
        end else if (dec_reg_write_en || dec_jump_en) begin
          next = S_WB;
        end else begin
          next = S_TRAP;
        end
      end
      S_MEM: begin
        dmem_we = dec_mem_write_en;
        if (dmem_ready) begin
          if (dec_mem_write_en) begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end else begin
            next = S_WB;
          end
        end else if (expired) begin
          next = S_TRAP;
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        wb_sel = dec_mem_to_reg;
        pc_we  = 1'b1;
        pc_src = dec_jump_en;
        retire = 1'b1;
      end
      S_TRAP:   if (trap_clr) next = S_IDLE;
      default:  next = S_TRAP;
    endcase
    if (retire) next = run ? S_FETCH : S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      retired <= '0;
    end else begin
      state <= next;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  assign imem_req = (state == S_FETCH);
  assign dmem_req = (state == S_MEM);
  assign trap     = (state == S_TRAP);
  assign busy     = (state != S_IDLE) && (state != S_TRAP);
  assign state_o  = state;
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle sequencing FSM for the RV32I core.
- Drives instruction fetch, IR latch, memory access, register writeback and PC update.
- Consumes the per-instruction control signals from the instruction decoder and the ALU zero flag; owns the imem/dmem request/ready handshakes.
- Sits between the decoder/ALU and the PC, IR, register file and memory ports.

Parameters:
- MEM_TIMEOUT, 16: max cycles a memory request may wait for ready before a bus-error trap (legal range 2..255).
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- run  in  1  1 = keep issuing instructions; 0 = stop at the next instruction boundary
- trap_clr  in  1  leaves TRAP and returns to IDLE
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data access complete this cycle
- dec_valid  in  1  decoder recognised the opcode
- dec_mem_write_en, dec_mem_to_reg, dec_reg_write_en, dec_branch_en, dec_jump_en  in  1 each  decoder control outputs
- alu_zero  in  1  ALU result == 0
- imem_req  out  1  fetch request
- ir_we  out  1  latch the instruction register
- dmem_req  out  1  data memory request
- dmem_we  out  1  data request is a write
- rf_we  out  1  register file write strobe
- wb_sel  out  1  0 = ALU result, 1 = memory data
- pc_we  out  1  PC update strobe
- pc_src  out  1  0 = PC+4, 1 = branch/jump target
- busy  out  1  state != IDLE and != TRAP
- trap  out  1  sticky error flag
- state_o  out  3  current state, for debug
- retired  out  CNT_W  retired-instruction count

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. While rst_n = 0: state = IDLE, all outputs 0, retired = 0, timeout counter = 0.
- State encodings: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, TRAP 6. Encoding 7 is illegal and goes to TRAP.
- Output timing: imem_req, dmem_req, busy, trap and state_o are Moore outputs. ir_we, pc_we, pc_src, rf_we, dmem_we and wb_sel are combinational from state plus inputs.
- IDLE: when run = 1, go to FETCH.
- FETCH:
  - imem_req = 1.
  - On imem_ready: ir_we = 1 that cycle, then go to DECODE.
- DECODE:
  - Single cycle.
  - dec_valid = 0 goes to TRAP; otherwise go to EXEC.
- EXEC:
  - Single cycle.
  - If dec_branch_en: retire here. pc_we = 1, pc_src = alu_zero.
  - Else if dec_mem_write_en or dec_mem_to_reg: go to MEM.
  - Else if dec_reg_write_en or dec_jump_en: go to WB.
  - Else: go to TRAP.
- MEM:
  - dmem_req = 1; dmem_we = dec_mem_write_en. Both are held until dmem_ready.
  - On ready, a store retires here (pc_we = 1, pc_src = 0); a load goes to WB.
- WB:
  - rf_we = 1 and wb_sel = dec_mem_to_reg, then retire.
  - pc_we = 1; pc_src = dec_jump_en.
- Retire:
  - retired increments by 1 and wraps at all-ones to 0.
  - Next state is FETCH if run = 1, else IDLE.
- Latency with ready asserted in the first request cycle:
  - Branch: 3 cycles.
  - R/I-type and store: 4 cycles.
  - Load: 5 cycles.
- Timeout:
  - An 8-bit counter clears on entry to FETCH/MEM and increments each cycle while the request is waiting.
  - If it reaches MEM_TIMEOUT-1 with no ready, go to TRAP.
  - If ready arrives in that same cycle, ready wins.
- TRAP:
  - trap = 1, all strobes 0, retired is held.
  - trap_clr = 1 goes to IDLE and clears trap.
  - run is ignored while in TRAP.
- Input stability: decoder inputs are sampled from DECODE through retire. The IR must not change in between; ir_we guarantees this.
- Reset mid-handshake: requests drop immediately. Memories must tolerate an abandoned request.
- run deassertion: never aborts an in-flight instruction.

Decomposition:
- Package ctrl_pkg holds:
  - the state localparams;
  - PC_SRC_SEQ/PC_SRC_TGT;
  - WB_ALU/WB_MEM;
  - the default MEM_TIMEOUT.
- Sub-module bus_timeout_counter: inputs clr, en; output expired; parameter LIMIT.
  - One instance, shared by FETCH and MEM.

Test Plan:
- Reset, run = 1, ADDI decode signals (valid, reg_write = 1), ready immediate: imem_req in cycle 1, ir_we in cycle 1, rf_we + pc_we (pc_src = 0) in cycle 4, retired = 1.
- Load: dmem_ready delayed 3 cycles. dmem_req held for 4 cycles with dmem_we = 0, then rf_we with wb_sel = 1; 8 cycles total.
- Branch, alu_zero = 1 then 0: pc_we in EXEC with pc_src = 1, then pc_src = 0; rf_we never asserted; retired = 2.
- dec_valid = 0: TRAP after DECODE, trap = 1, all strobes 0. run toggling has no effect; trap_clr returns to IDLE.
- imem_ready never asserted, MEM_TIMEOUT = 16: TRAP entered after 16 FETCH cycles. Repeat with ready in cycle 16: no trap.
- run dropped during MEM of a store: store completes, then IDLE; rst_n pulsed mid-FETCH clears all outputs asynchronously.
